keypad_hit_conditioner: RTL and testbench
=========================================

Name: keypad_hit_conditioner

Overview:
Upstream input stage for the mole game logic. Conditions the 8 raw one-hot keypad lines: 2-flop synchronisation, per-key debounce, press-edge detection. Delivers one key hit per transaction through a 4-entry event FIFO with a valid/ready handshake. The game logic consumes exactly one registered hit per accepted event, not raw key levels.

Parameters:
DEBOUNCE_CYCLES, 50000, cycles a synchronised key must differ from its debounced state before the debounced state flips (min 2)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
FIFO_DEPTH, 4, event FIFO entries (power of 2, fixed at 4 for count width)

Ports:
clk  in  1  system clock
RESET  in  1  asynchronous active-low reset (0 = reset)
keypad  in  8  raw key lines, 1 = pressed, asynchronous to clk
key_level  out  8  debounced key state
hit_valid  out  1  FIFO head holds an event
hit_ready  in  1  consumer accepts head this cycle
hit_key  out  3  index of head event key
hit_onehot  out  8  one-hot of hit_key; all zero when hit_valid=0
hit_release  out  1  head event is a release (see Optional Feature)
fifo_count  out  3  occupied entries, 0..4
overflow  out  1  sticky: a press was lost
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (RESET=0, async): sync flops, key_level, counters, pending vectors, FIFO pointers cleared. hit_valid=0, hit_onehot=0, hit_key=0, hit_release=0, fifo_count=0, overflow=0.
- Sync: keypad -> s1 -> s2, one flop each per bit.
- Debounce, per key: if s2 == key_level[i], counter cleared. Otherwise counter increments. When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, key_level[i] flips and the counter clears on the same edge. A glitch shorter than DEBOUNCE_CYCLES cycles never changes key_level.
- Edge detect: key_level[i] 0->1 sets press_pending[i] on the same edge the level flips.
- Arbitration: each cycle, the lowest-index set pending bit is selected. If a push is possible, that event is written to the FIFO and its pending bit clears. One push per cycle max. Remaining keys wait in later cycles, lowest index first.
- Push possible when fifo_count < 4, or when fifo_count == 4 and a pop occurs the same cycle.
- Pop: when hit_valid & hit_ready, the head advances. Outputs are show-ahead from FIFO storage, registered, with no combinational path from keypad.
- Simultaneous push and pop: fifo_count is unchanged. Ordering is preserved.
- Latency: a clean key press held steady reaches key_level after DEBOUNCE_CYCLES+2 edges. With an empty FIFO, hit_valid rises after DEBOUNCE_CYCLES+4 edges.
- Overflow: a new press edge on key i while press_pending[i] is still set (its previous press not yet queued) sets overflow. The new edge merges into the pending bit and is lost. overflow stays 1 until ovf_clr=1 or reset. If ovf_clr and a new overflow occur in the same cycle, the set wins.
- fifo_count is 3-bit, 0..4. Pointers wrap modulo 4.
- Reset mid-operation clears all state immediately. No event survives reset.

Optional Feature:
KEYPAD_RELEASE_EVT_EN
- Defined: key_level[i] 1->0 sets release_pending[i]. Arbitration order is all press_pending first (lowest index), then release_pending (lowest index). FIFO entries carry a release bit, driven on hit_release. Overflow also covers a release edge while release_pending[i] is set.
- Not defined: no release tracking logic. hit_release is tied 0. Only press events are queued.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
- Reset: RESET=0 with keypad=8'hFF -> all outputs 0. Release reset, hold keypad=8'h04 -> key_level[2]=1 at edge 6, hit_valid=1 at edge 8 with hit_key=2, hit_onehot=8'h04. hit_ready=1 -> hit_valid=0 next edge.
- Glitch: pulse keypad[5] high for 3 cycles, then low -> key_level stays 0, no event, fifo_count=0.
- Simultaneous press: keypad 0->8'h81 with hit_ready=0 -> events queued key 0 then key 7 on consecutive edges, fifo_count=2. Popping yields 0 then 7.
- Full FIFO: hit_ready=0, press keys 1,2,3,4,5 sequentially -> fifo_count=4, key 5 stays pending, overflow=0. Then press and release key 5 again before any pop -> overflow=1. Single pop -> key 5 queued the same cycle, fifo_count stays 4. ovf_clr -> overflow=0.
- Push/pop same cycle at count 2 -> fifo_count stays 2, order intact.
- Macro defined: press and release key 3 -> two events, hit_key=3 with hit_release=0, then hit_key=3 with hit_release=1. Macro undefined -> only the press event, hit_release=0 always.

Source files
------------

// File: rtl/keypad_hit_conditioner.sv
// keypad_hit_conditioner: sync, debounce and press-edge detect 8 keypad lines into a 4-entry hit FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue key releases, flagged on hit_release.
module keypad_hit_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic [7:0] keypad,
   output logic [7:0] key_level,
   output logic       hit_valid,
   input  logic       hit_ready,
   output logic [2:0] hit_key,
   output logic [7:0] hit_onehot,
   output logic       hit_release,
   output logic [2:0] fifo_count,
   output logic       overflow,
   input  logic       ovf_clr
);
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam int EV = 16;
`else
   localparam int EV = 8;
`endif
   localparam int EW = $clog2(EV);
   logic [7:0] s1, s2, flip;
   logic [CNT_W-1:0] cnt [8];
   logic [EV-1:0] pend, evt, clr;
   logic [EW-1:0] sel, head;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [1:0] wp, rp, rp_n;
   logic [2:0] vis;
   logic any, pop, push;
   // Press events occupy the low pending bits, so lowest-index-first also gives presses priority.
   always_comb begin
      for (int i = 0; i < 8; i++)
         flip[i] = (s2[i] != key_level[i]) && (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
`ifdef KEYPAD_RELEASE_EVT_EN
      evt = {flip & key_level, flip & ~key_level};
`else
      evt = flip & ~key_level;
`endif
      sel = '0;
      any = 1'b0;
      for (int j = EV - 1; j >= 0; j--)
         if (pend[j]) begin
            sel = EW'(j);
            any = 1'b1;
         end
      pop  = hit_valid & hit_ready;
      push = any && (fifo_count != 3'd4 || pop);
      clr  = push ? EV'(1) << sel : '0;
      rp_n = rp + {1'b0, pop};
      vis  = fifo_count - {2'b0, pop};
      head = mem[rp_n];
   end
   // Outputs show storage after this cycle's pop; a fresh push becomes visible one edge later.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         s1          <= '0;
         s2          <= '0;
         key_level   <= '0;
         pend        <= '0;
         wp          <= '0;
         rp          <= '0;
         fifo_count  <= '0;
         overflow    <= 1'b0;
         hit_valid   <= 1'b0;
         hit_key     <= '0;
         hit_onehot  <= '0;
         hit_release <= 1'b0;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else begin
         s1 <= keypad;
         s2 <= s1;
         for (int i = 0; i < 8; i++)
            cnt[i] <= (s2[i] == key_level[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
         key_level  <= key_level ^ flip;
         pend       <= (pend & ~clr) | evt;
         overflow   <= (|(evt & pend & ~clr)) | (overflow & ~ovf_clr);
         wp         <= wp + {1'b0, push};
         rp         <= rp_n;
         fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};
         hit_valid  <= vis != 3'd0;
         hit_key    <= vis != 3'd0 ? head[2:0] : 3'd0;
         hit_onehot <= vis != 3'd0 ? 8'd1 << head[2:0] : 8'd0;
`ifdef KEYPAD_RELEASE_EVT_EN
         hit_release <= vis != 3'd0 && head[EW-1];
`else
         hit_release <= 1'b0;
`endif
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= sel;
endmodule

// File: tb/tb_keypad_hit_conditioner.sv
// tb_keypad_hit_conditioner: directed stimulus with DEBOUNCE_CYCLES=4; expected hits are queued
// by the stimulus and a negedge monitor pops and compares each accepted FIFO head.
`timescale 1ns/1ps
module tb_keypad_hit_conditioner;
   logic       clk = 1'b0, RESET = 1'b0, hit_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] keypad = 8'hFF;
   logic [7:0] key_level, hit_onehot, seen;
   logic       hit_valid, hit_release, overflow;
   logic [2:0] hit_key, fifo_count;
   logic [3:0] exp_q [$];
   logic [3:0] e;
   int checks = 0, errors = 0;
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   keypad_hit_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .RESET(RESET), .keypad(keypad), .key_level(key_level),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_key(hit_key),
      .hit_onehot(hit_onehot), .hit_release(hit_release), .fifo_count(fifo_count),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic rel, input logic [2:0] key);
      if (!rel || REL) exp_q.push_back({rel, key});
   endtask

   always @(negedge clk) begin
      if (RESET && hit_valid && hit_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hit: got key %0d release %0b, want no event", hit_key, hit_release);
         end else begin
            e = exp_q.pop_front();
            chk("hit_key", {29'd0, hit_key}, {29'd0, e[2:0]});
            chk("hit_onehot", {24'd0, hit_onehot}, 32'd1 << e[2:0]);
            chk("hit_release", {31'd0, hit_release}, {31'd0, e[3]});
         end
      end else if (RESET && !hit_valid)
         chk("onehot_idle", {24'd0, hit_onehot}, 32'd0);
   end

   initial begin
      step(3);
      chk("rst_key_level", key_level, 0);
      chk("rst_hit_valid", hit_valid, 0);
      chk("rst_hit_onehot", hit_onehot, 0);
      chk("rst_hit_key", hit_key, 0);
      chk("rst_hit_release", hit_release, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      RESET = 1'b1;
      keypad = 8'h04;
      ev(0, 2);
      step(5);
      chk("lvl_edge5", key_level, 8'h00);
      step(1);
      chk("lvl_edge6", key_level, 8'h04);
      step(1);
      chk("valid_edge7", hit_valid, 0);
      step(1);
      chk("valid_edge8", hit_valid, 1);
      chk("key_edge8", hit_key, 2);
      chk("onehot_edge8", hit_onehot, 8'h04);
      hit_ready = 1'b1;
      step(1);
      chk("valid_after_pop", hit_valid, 0);
      keypad = 8'h00;
      ev(1, 2);
      step(12);
      keypad = 8'h20;
      step(3);
      keypad = 8'h00;
      seen = 8'h00;
      for (int i = 0; i < 10; i++) begin
         step(1);
         seen |= key_level;
      end
      chk("glitch_level", seen, 0);
      chk("glitch_count", fifo_count, 0);
      hit_ready = 1'b0;
      keypad = 8'h81;
      ev(0, 0);
      ev(0, 7);
      step(7);
      chk("simul_count1", fifo_count, 1);
      step(1);
      chk("simul_count2", fifo_count, 2);
      chk("simul_head", hit_key, 0);
      hit_ready = 1'b1;
      step(4);
      chk("simul_drained", fifo_count, 0);
      keypad = 8'h00;
      ev(1, 0);
      ev(1, 7);
      step(16);
      hit_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         keypad[k] = 1'b1;
         ev(0, 3'(k));
         step(8);
      end
      ev(1, 5);
      chk("full_count", fifo_count, 4);
      chk("full_no_ovf", overflow, 0);
      chk("full_level", key_level, 8'h3E);
      keypad = 8'h1E;
      step(8);
      keypad = 8'h3E;
      step(8);
      chk("ovf_set", overflow, 1);
      hit_ready = 1'b1;
      step(1);
      hit_ready = 1'b0;
      chk("full_pop_push", fifo_count, 4);
      chk("ovf_sticky", overflow, 1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 0);
      hit_ready = 1'b1;
      step(12);
      chk("full_drained", fifo_count, 0);
      keypad = 8'h00;
      for (int k = 1; k <= 5; k++) ev(1, 3'(k));
      step(16);
      hit_ready = 1'b0;
      keypad = 8'h40;
      ev(0, 6);
      step(8);
      keypad = 8'h41;
      ev(0, 0);
      step(8);
      chk("pp_count_before", fifo_count, 2);
      keypad = 8'h43;
      ev(0, 1);
      step(6);
      hit_ready = 1'b1;
      step(1);
      hit_ready = 1'b0;
      chk("pp_count_same", fifo_count, 2);
      hit_ready = 1'b1;
      step(8);
      chk("pp_drained", fifo_count, 0);
      keypad = 8'h00;
      ev(1, 0);
      ev(1, 1);
      ev(1, 6);
      step(16);
      keypad = 8'h08;
      ev(0, 3);
      step(12);
      keypad = 8'h00;
      ev(1, 3);
      step(12);
      chk("rel_drained", fifo_count, 0);
      hit_ready = 1'b0;
      keypad = 8'h10;
      step(8);
      chk("mid_count", fifo_count, 1);
      RESET = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_valid", hit_valid, 0);
      chk("mid_rst_level", key_level, 0);
      keypad = 8'h00;
      step(2);
      RESET = 1'b1;
      step(10);
      chk("post_rst_valid", hit_valid, 0);
      chk("post_rst_count", fifo_count, 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
